pool_unit_seq: RTL and testbench
================================

Name: pool_unit_seq

Overview:
- Streaming fp16 pooling unit. Consumes WINDOW samples one per cycle over a valid/ready handshake, reduces them by average or max, and emits one pooled fp16 result per window.
- Sits between the conv feature-map output stream and the next layer's input buffer.
- Reuses the team's floatAdd16 and floatMult16 combinational primitives (fp16, 1/5/10).

Parameters:
- DATA_WIDTH, 16, sample width; fixed at 16 by the fp16 primitives; any other value is a configuration error.
- WINDOW, 4, samples per pooled output; must be a power of two, 1..64.
- SCALE, derived as fp16 2^-log2(WINDOW): sign 0, exponent 15-log2(WINDOW), mantissa 0; 0x3400 for WINDOW=4.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous abort of the current window.
- mode  in  1  0 = average, 1 = max; sampled with the first sample of each window.
- in_data  in  16  fp16 sample.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  unit accepts a sample this cycle.
- out_data  out  16  pooled fp16 result.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.

Behaviour:
- Clock and reset: one clock (clk); reset_n is asynchronous, active-low.
- Reset values: state=ACCUM, count=0, acc=0x0000, mode_q=0, out_data=0x0000, out_valid=0. in_ready is 1 as soon as reset_n deasserts.
- Handshake: a transfer occurs when valid&&ready on a rising edge. out_data and out_valid hold stable while out_valid=1 and out_ready=0.
- FSM, state ACCUM:
  - in_ready=1.
  - On accept with count==0: acc<=in_data; mode_q<=mode.
  - On accept with count>0: acc<=floatAdd16(acc,in_data) when mode_q=0; acc<=fmax(acc,in_data) when mode_q=1.
  - count increments on each accept. On the accept where count==WINDOW-1: count<=0 and go to SCALE.
- FSM, state SCALE:
  - in_ready=0.
  - out_data<=floatMult16(acc,SCALE) when mode_q=0, else out_data<=acc.
  - out_valid<=1; go to OUT. Always one cycle.
- FSM, state OUT:
  - in_ready=0.
  - On out_ready: out_valid<=0; go to ACCUM.
- Latency and throughput:
  - out_valid rises 2 cycles after the last sample is accepted.
  - Minimum period is WINDOW+2 cycles per output.
- WINDOW=1: every accept goes straight to SCALE. Avg result is x*1.0 (SCALE=0x3C00).
- fmax: sign-magnitude compare.
  - Positive beats negative.
  - Between two positives, the larger {exp,mant} wins; between two negatives, the smaller {exp,mant} wins.
  - On equality (including +0 vs -0), acc is kept.
  - NaN/Inf are not special-cased.
- Mode changes mid-window are ignored until the next window.
- Boundary cases:
  - clear in any state: state<=ACCUM, count<=0, out_valid<=0, and any pending output is dropped. clear has priority over a simultaneous accept, and that sample is discarded.
  - reset_n asserted mid-window or mid-OUT: immediate return to the reset values; no partial result is emitted.
  - in_valid with no handshake in SCALE/OUT: the sample is not consumed, and upstream must hold it.

Optional Feature:
- Macro: POOL_RELU_EN.
- Defined: in SCALE, if the pooled result has sign bit 1, out_data<=0x0000 (fused ReLU; -0 also becomes 0x0000). Applies to both modes; timing is unchanged.
- Undefined: the result is passed unmodified.

Test Plan:
- Avg, WINDOW=4, mode=0, samples 0x3C00,0x4000,0x4200,0x4400 back-to-back, out_ready=1.
  - Required: in_ready drops after the 4th accept.
  - Required: out_data=0x4100 (2.5) with out_valid=1 exactly 2 cycles after the 4th accept, for 1 cycle.
- Max, mode=1, samples 0xC000,0x3C00,0x4200,0xBC00 -> out_data=0x4200. Repeat with all-negative 0xC400,0xBC00,0xC200,0xC000 -> 0xBC00.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - Required: out_data and out_valid stable, in_ready=0 throughout.
  - Required: after out_ready=1, the next window is accepted starting the following cycle.
- Gapped input: in_valid toggled 1/0 across 8 cycles with samples 0x4000 x4 -> out_data=0x4000. The result is unaffected by the gaps.
- clear asserted after 2 accepted samples, then 4 samples 0x4400 -> out_data=0x4400; the aborted partial window is never output. Repeat with reset_n pulsed low in OUT -> out_valid=0 immediately, and in_ready=1 after release.
- With POOL_RELU_EN: avg of 0xBC00,0xC000,0xC200,0xC400 -> 0x0000. Without it -> 0xC100.

Source files
------------

// File: rtl/pool_unit_seq.sv
// Streaming fp16 pooling unit: reduces WINDOW samples by average or max and emits one fp16 result.
// Optional macro POOL_RELU_EN clamps negative pooled results to +0 (fused ReLU).
module pool_unit_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int WINDOW     = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  mode,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int LOG2W = $clog2(WINDOW);
    localparam int CNT_W = (WINDOW > 1) ? LOG2W : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);
    localparam logic [15:0] SCALE = {1'b0, 5'(15 - LOG2W), 10'b0};

    if (DATA_WIDTH != 16) begin : g_bad_width
        $error("pool_unit_seq: DATA_WIDTH must be 16");
    end
    if (WINDOW < 1 || WINDOW > 64 || (WINDOW & (WINDOW - 1)) != 0) begin : g_bad_window
        $error("pool_unit_seq: WINDOW must be a power of two in 1..64");
    end

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_SCALE = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    // fp16 add, round-to-nearest-even; magnitudes aligned with a sticky bit kept in bit 0
    function automatic logic [15:0] floatAdd16(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x, y;
        logic [4:0]  ex, ey;
        logic [14:0] mx, my, sum;
        logic        lost, rnd;
        logic [11:0] m;
        int          e, d;
        if (b[14:0] > a[14:0]) begin
            x = b; y = a;
        end else begin
            x = a; y = b;
        end
        if (x[14:10] == 5'h1f) return x;
        ex  = (x[14:10] == 5'd0) ? 5'd1 : x[14:10];
        ey  = (y[14:10] == 5'd0) ? 5'd1 : y[14:10];
        mx  = {1'b0, x[14:10] != 5'd0, x[9:0], 3'b000};
        my  = {1'b0, y[14:10] != 5'd0, y[9:0], 3'b000};
        d   = int'(ex) - int'(ey);
        if (d > 13) begin
            my = {14'b0, |my};
        end else begin
            for (int i = 0; i < 13; i++) begin
                if (i < d) begin
                    lost  = my[0];
                    my    = my >> 1;
                    my[0] = my[0] | lost;
                end
            end
        end
        e = int'(ex);
        if (x[15] == y[15]) sum = mx + my;
        else                sum = mx - my;
        if (sum == 15'd0) return 16'h0000;
        if (sum[14]) begin
            sum = {1'b0, sum[14:1]} | {14'b0, sum[0]};
            e   = e + 1;
        end
        for (int i = 0; i < 13; i++) begin
            if (!sum[13] && e > 1) begin
                sum = sum << 1;
                e   = e - 1;
            end
        end
        rnd = sum[2] & (sum[1] | sum[0] | sum[3]);
        m   = {1'b0, sum[13:3]} + {11'b0, rnd};
        if (m[11]) begin
            m = m >> 1;
            e = e + 1;
        end
        if (e >= 31) return {x[15], 5'h1f, 10'h000};
        return {x[15], m[10] ? 5'(e) : 5'd0, m[9:0]};
    endfunction

    // fp16 multiply, round-to-nearest-even, subnormal inputs and outputs handled
    function automatic logic [15:0] floatMult16(input logic [15:0] a, input logic [15:0] b);
        logic        s, sticky, rnd;
        logic [10:0] ma, mb;
        logic [21:0] p;
        logic [11:0] m;
        int          e;
        s = a[15] ^ b[15];
        if (a[14:10] == 5'h1f || b[14:10] == 5'h1f) return {s, 5'h1f, 10'h000};
        if (a[14:0] == 15'd0 || b[14:0] == 15'd0) return {s, 15'h0000};
        ma = {a[14:10] != 5'd0, a[9:0]};
        mb = {b[14:10] != 5'd0, b[9:0]};
        e  = int'((a[14:10] == 5'd0) ? 5'd1 : a[14:10])
           + int'((b[14:10] == 5'd0) ? 5'd1 : b[14:10]) - 15;
        p  = 22'(ma) * 22'(mb);
        sticky = 1'b0;
        if (p[21]) begin
            sticky = p[0];
            p      = p >> 1;
            e      = e + 1;
        end
        for (int i = 0; i < 21; i++) begin
            if (!p[20] && e > 1) begin
                p = p << 1;
                e = e - 1;
            end
        end
        for (int i = 0; i < 24; i++) begin
            if (e < 1) begin
                sticky = sticky | p[0];
                p      = p >> 1;
                e      = e + 1;
            end
        end
        rnd = p[9] & ((|p[8:0]) | sticky | p[10]);
        m   = {1'b0, p[20:10]} + {11'b0, rnd};
        if (m[11]) begin
            m = m >> 1;
            e = e + 1;
        end
        if (e >= 31) return {s, 5'h1f, 10'h000};
        return {s, m[10] ? 5'(e) : 5'd0, m[9:0]};
    endfunction

    // Sign-magnitude max; ties (including +0 vs -0) keep the accumulator a
    function automatic logic [15:0] fmax16(input logic [15:0] a, input logic [15:0] b);
        if (a[14:0] == 15'd0 && b[14:0] == 15'd0) return a;
        if (a[15] != b[15]) return a[15] ? b : a;
        if (!a[15]) return (b[14:0] > a[14:0]) ? b : a;
        return (b[14:0] < a[14:0]) ? b : a;
    endfunction

    function automatic logic [15:0] relu16(input logic [15:0] v);
`ifdef POOL_RELU_EN
        return v[15] ? 16'h0000 : v;
`else
        return v;
`endif
    endfunction

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic [15:0]      r_acc;
    logic             r_mode_q;
    logic [15:0]      r_out_data;
    logic             r_out_valid;
    logic             r_in_ready;

    logic [15:0] w_next_acc;
    logic [15:0] w_result;

    always_comb begin
        w_next_acc = r_mode_q ? fmax16(r_acc, in_data) : floatAdd16(r_acc, in_data);
        w_result   = relu16(r_mode_q ? r_acc : floatMult16(r_acc, SCALE));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_ACCUM;
            r_count     <= '0;
            r_acc       <= 16'h0000;
            r_mode_q    <= 1'b0;
            r_out_data  <= 16'h0000;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else if (clear) begin
            r_state     <= ST_ACCUM;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (in_valid) begin
                        if (r_count == '0) begin
                            r_acc    <= in_data;
                            r_mode_q <= mode;
                        end else begin
                            r_acc <= w_next_acc;
                        end
                        if (r_count == LAST) begin
                            r_count    <= '0;
                            r_state    <= ST_SCALE;
                            r_in_ready <= 1'b0;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                ST_SCALE: begin
                    r_out_data  <= w_result;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_ACCUM;
                    end
                end
                default: begin
                    r_state    <= ST_ACCUM;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_pool_unit_seq.sv
// Scoreboard bench for pool_unit_seq (WINDOW=4): expected results are queued at issue, popped by a monitor.
module tb_pool_unit_seq;

    logic        clk       = 1'b0;
    logic        reset_n   = 1'b0;
    logic        clear     = 1'b0;
    logic        mode      = 1'b0;
    logic [15:0] in_data   = 16'h0000;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b1;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    pool_unit_seq #(.DATA_WIDTH(16), .WINDOW(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .mode      (mode),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, req);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out, got no event, expected one within 40 cycles", name);
    endtask

    // Monitor: one pop per completed output transfer
    always @(negedge clk) begin
        logic [15:0] e;
        if (reset_n && !clear && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got 0x%04h, expected no output", out_data);
            end else begin
                e = exp_q.pop_front();
                chk16("out_data", out_data, e);
            end
        end
    end

    // All driving tasks start and end 1 time unit after a rising edge
    task automatic send_sample(input logic [15:0] d, input logic m);
        int n = 0;
        in_data  = d;
        mode     = m;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) timeout("send_sample");
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 16'hFFFF;
    endtask

    task automatic send_window(input logic m, input logic [63:0] v, input bit gap);
        for (int i = 0; i < 4; i++) begin
            send_sample(v[63-16*i -: 16], (i == 0) ? m : ~m);
            if (gap && i < 3) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) timeout("wait_ready");
    endtask

    task automatic wait_out_valid();
        int n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) timeout("wait_out_valid");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_out_valid", out_valid, 1'b0);
        chk16("rst_out_data", out_data, 16'h0000);
        chk1("rst_in_ready", in_ready, 1'b1);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk1("post_rst_in_ready", in_ready, 1'b1);

        // Average 1,2,3,4 -> 2.5, latency and single-cycle valid
        exp_q.push_back(16'h4100);
        send_window(1'b0, {16'h3C00, 16'h4000, 16'h4200, 16'h4400}, 1'b0);
        chk1("in_ready_drop", in_ready, 1'b0);
        chk1("latency_early", out_valid, 1'b0);
        @(posedge clk); #1;
        chk1("latency_valid", out_valid, 1'b1);
        chk16("latency_data", out_data, 16'h4100);
        @(posedge clk); #1;
        chk1("valid_one_cycle", out_valid, 1'b0);
        chk1("ready_back", in_ready, 1'b1);

        // Max with mixed signs, then all negative; mode toggles mid-window
        exp_q.push_back(16'h4200);
        send_window(1'b1, {16'hC000, 16'h3C00, 16'h4200, 16'hBC00}, 1'b0);
        exp_q.push_back(16'hBC00);
        send_window(1'b1, {16'hC400, 16'hBC00, 16'hC200, 16'hC000}, 1'b0);

        // Backpressure with a sample waiting upstream
        wait_ready();
        out_ready = 1'b0;
        exp_q.push_back(16'h4500);
        send_window(1'b1, {16'h3800, 16'h4500, 16'h4480, 16'h4400}, 1'b0);
        wait_out_valid();
        in_valid = 1'b1;
        in_data  = 16'h4600;
        mode     = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk1("bp_valid", out_valid, 1'b1);
            chk16("bp_data", out_data, 16'h4500);
            chk1("bp_in_ready", in_ready, 1'b0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk1("bp_release_ready", in_ready, 1'b1);
        chk1("bp_release_valid", out_valid, 1'b0);
        exp_q.push_back(16'h4600);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) send_sample(16'h4600, 1'b0);

        // Gapped input
        exp_q.push_back(16'h4000);
        send_window(1'b0, {16'h4000, 16'h4000, 16'h4000, 16'h4000}, 1'b1);

        // clear after two samples; the colliding sample is discarded
        send_sample(16'h4000, 1'b0);
        send_sample(16'h4000, 1'b0);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h7000;
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        chk1("clear_ready", in_ready, 1'b1);
        exp_q.push_back(16'h4400);
        send_window(1'b0, {16'h4400, 16'h4400, 16'h4400, 16'h4400}, 1'b0);

        // Reset pulsed while a result waits in OUT; nothing is emitted
        wait_ready();
        out_ready = 1'b0;
        send_window(1'b0, {16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00}, 1'b0);
        wait_out_valid();
        #2 reset_n = 1'b0;
        #1;
        chk1("rst_out_valid_async", out_valid, 1'b0);
        chk16("rst_out_data_async", out_data, 16'h0000);
        chk1("rst_in_ready_async", in_ready, 1'b1);
        @(posedge clk); #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk1("rst_release_ready", in_ready, 1'b1);
        chk1("rst_release_valid", out_valid, 1'b0);

        // Negative average: ReLU clamps when enabled
`ifdef POOL_RELU_EN
        exp_q.push_back(16'h0000);
`else
        exp_q.push_back(16'hC100);
`endif
        send_window(1'b0, {16'hBC00, 16'hC000, 16'hC200, 16'hC400}, 1'b0);
        wait_ready();
        repeat (3) @(posedge clk);
        #1;
        chk16("queue_empty", 16'(exp_q.size()), 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
